mem_access_unit: RTL and testbench

MEM-stage load/store requester that drives the single-port, byte-enabled, synchronous-read data memory. It accepts byte-addressed RISC-V load/store requests and generates the memory word address, byte write enables and lane-replicated store data. After the 1-cycle memory read latency, it extracts and sign- or zero-extends load data. Responses use a valid/ready handshake. A hold register preserves the response under backpressure.

---
 rtl/mem_access_unit.sv | 168 ++++++++++++++++
 tb/tb_mem_access_unit.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// MEM-stage load/store requester for a byte-enabled synchronous-read RAM.
// Formats load data one cycle after the request; holds the response under backpressure.
module mem_access_unit #(
  parameter int WIDTH     = 32,
  parameter int SIZE      = 256,
  parameter int NUM_COL   = 4,
  parameter int COL_WIDTH = 8,
  localparam int LOGSIZE  = $clog2(SIZE)
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic               req_we,
  input  logic [2:0]         req_funct3,
  input  logic [31:0]        req_addr,
  input  logic [WIDTH-1:0]   req_wdata,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [WIDTH-1:0]   rsp_rdata,
  output logic               rsp_err,
  output logic [LOGSIZE-1:0] mem_word_addr,
  output logic [NUM_COL-1:0] mem_byte_wr_en,
  output logic [WIDTH-1:0]   mem_data_in,
  input  logic [WIDTH-1:0]   mem_data_out
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RESP,
    S_HOLD
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [1:0]         w_off;
  logic               w_accept;
  logic               w_illegal;
  logic               w_misal;
  logic               w_err;
  logic [NUM_COL-1:0] w_mask;
  logic [WIDTH-1:0]   w_wdata;
  logic               w_unused;

  logic               r_we;
  logic [2:0]         r_f3;
  logic [1:0]         r_off;
  logic               r_err;
  logic [WIDTH-1:0]   r_hold_data;
  logic               r_hold_err;

  logic [WIDTH-1:0]   w_lane;
  logic [WIDTH-1:0]   w_fmt;

  assign w_off         = req_addr[1:0];
  assign mem_word_addr = req_addr[LOGSIZE+1:2];
  assign w_unused      = ^req_addr[31:LOGSIZE+2];

  assign req_ready = (r_state == S_IDLE) ||
                     ((r_state == S_RESP) && rsp_ready);
  assign w_accept  = req_valid && req_ready;

  always_comb begin
    w_mask    = '0;
    w_wdata   = req_wdata;
    w_illegal = 1'b0;
    w_misal   = 1'b0;
    unique case (req_funct3[1:0])
      2'b00: begin
        w_mask  = {{(NUM_COL-1){1'b0}}, 1'b1};
        w_wdata = {NUM_COL{req_wdata[COL_WIDTH-1:0]}};
      end
      2'b01: begin
        w_mask  = {{(NUM_COL-2){1'b0}}, 2'b11};
        w_wdata = {(NUM_COL/2){req_wdata[2*COL_WIDTH-1:0]}};
        w_misal = w_off[0];
      end
      2'b10: begin
        w_mask  = '1;
        w_misal = |w_off;
      end
      default: w_illegal = 1'b1;
    endcase
    // Unsigned variants exist only for byte/half loads
    if (req_funct3[2] && (req_we || req_funct3[1]))
      w_illegal = 1'b1;
  end

  assign w_err       = w_illegal || w_misal;
  assign mem_data_in = w_wdata;

  assign mem_byte_wr_en =
    (reset_n && w_accept && req_we && !w_err) ?
    (w_mask << w_off) : '0;

  assign w_lane = mem_data_out >> {r_off, 3'b000};

  always_comb begin
    w_fmt = '0;
    unique case (r_f3)
      3'b000:  w_fmt = {{(WIDTH-8){w_lane[7]}}, w_lane[7:0]};
      3'b001:  w_fmt = {{(WIDTH-16){w_lane[15]}}, w_lane[15:0]};
      3'b010:  w_fmt = mem_data_out;
      3'b100:  w_fmt = {{(WIDTH-8){1'b0}}, w_lane[7:0]};
      3'b101:  w_fmt = {{(WIDTH-16){1'b0}}, w_lane[15:0]};
      default: w_fmt = '0;
    endcase
    if (r_we || r_err)
      w_fmt = '0;
  end

  always_comb begin
    w_next    = r_state;
    rsp_valid = 1'b0;
    rsp_rdata = '0;
    rsp_err   = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_accept)
          w_next = S_RESP;
      end
      S_RESP: begin
        rsp_valid = 1'b1;
        rsp_rdata = w_fmt;
        rsp_err   = r_err;
        if (!rsp_ready)
          w_next = S_HOLD;
        else if (!w_accept)
          w_next = S_IDLE;
      end
      S_HOLD: begin
        rsp_valid = 1'b1;
        rsp_rdata = r_hold_data;
        rsp_err   = r_hold_err;
        if (rsp_ready)
          w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_we        <= 1'b0;
      r_f3        <= '0;
      r_off       <= '0;
      r_err       <= 1'b0;
      r_hold_data <= '0;
      r_hold_err  <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_we  <= req_we;
        r_f3  <= req_funct3;
        r_off <= w_off;
        r_err <= w_err;
      end
      // Memory output moves on next cycle, so snapshot the response
      if ((r_state == S_RESP) && !rsp_ready) begin
        r_hold_data <= w_fmt;
        r_hold_err  <= r_err;
      end
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit with a byte-enabled
// synchronous-read memory model.
module tb_mem_access_unit;

  logic        clk;
  logic        reset_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [7:0]  mem_word_addr;
  logic [3:0]  mem_byte_wr_en;
  logic [31:0] mem_data_in;
  logic [31:0] mem_data_out;

  int checks = 0;
  int errors = 0;
  logic [32:0] q[$];
  logic [31:0] mem [0:255];

  mem_access_unit dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_we         (req_we),
    .req_funct3     (req_funct3),
    .req_addr       (req_addr),
    .req_wdata      (req_wdata),
    .rsp_valid      (rsp_valid),
    .rsp_ready      (rsp_ready),
    .rsp_rdata      (rsp_rdata),
    .rsp_err        (rsp_err),
    .mem_word_addr  (mem_word_addr),
    .mem_byte_wr_en (mem_byte_wr_en),
    .mem_data_in    (mem_data_in),
    .mem_data_out   (mem_data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    for (int i = 0; i < 256; i++)
      mem[i] = 32'h0;
  end

  always @(posedge clk) begin
    for (int i = 0; i < 4; i++)
      if (mem_byte_wr_en[i])
        mem[mem_word_addr][i*8 +: 8] <= mem_data_in[i*8 +: 8];
    mem_data_out <= mem[mem_word_addr];
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (reset_n && rsp_valid && rsp_ready) begin
      logic [32:0] e;
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_rsp: got %h expected none", rsp_rdata);
      end else begin
        e = q.pop_front();
        chk("rsp_rdata", rsp_rdata, e[31:0]);
        chk("rsp_err", {31'h0, rsp_err}, {31'h0, e[32]});
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 after the accept edge
  task automatic issue(input logic we, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wd,
                       input logic [31:0] exp_rd, input logic exp_err,
                       input logic [3:0] exp_wen, input logic [31:0] exp_din,
                       input logic push);
    int n;
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wd;
    #1;
    n = 0;
    while (!req_ready && n < 20) begin
      @(posedge clk);
      #2;
      n++;
    end
    if (!req_ready) begin
      checks++;
      errors++;
      $display("FAIL req_ready_timeout: got 0 expected 1");
    end
    chk("wr_en", {28'h0, mem_byte_wr_en}, {28'h0, exp_wen});
    chk("word_addr", {24'h0, mem_word_addr}, {24'h0, addr[9:2]});
    if (we)
      chk("data_in", mem_data_in, exp_din);
    if (push)
      q.push_back({exp_err, exp_rd});
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  initial begin
    int n;
    reset_n    = 1'b0;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_funct3 = 3'b000;
    req_addr   = 32'h0;
    req_wdata  = 32'h0;
    rsp_ready  = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    chk("rst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
    chk("rst_rsp_rdata", rsp_rdata, 32'h0);
    chk("rst_rsp_err", {31'h0, rsp_err}, 32'h0);
    chk("rst_req_ready", {31'h0, req_ready}, 32'h1);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    issue(1, 3'b010, 32'h10, 32'hDEADBEEF, 32'h0, 0, 4'b1111, 32'hDEADBEEF, 1);
    issue(0, 3'b000, 32'h13, 32'h0, 32'hFFFFFFDE, 0, 4'b0000, 32'h0, 1);
    issue(0, 3'b100, 32'h13, 32'h0, 32'h000000DE, 0, 4'b0000, 32'h0, 1);
    issue(0, 3'b001, 32'h12, 32'h0, 32'hFFFFDEAD, 0, 4'b0000, 32'h0, 1);
    issue(0, 3'b101, 32'h10, 32'h0, 32'h0000BEEF, 0, 4'b0000, 32'h0, 1);
    issue(1, 3'b000, 32'h11, 32'h7A, 32'h0, 0, 4'b0010, 32'h7A7A7A7A, 1);
    issue(0, 3'b010, 32'h10, 32'h0, 32'hDEAD7AEF, 0, 4'b0000, 32'h0, 1);
    issue(0, 3'b010, 32'h12, 32'h0, 32'h0, 1, 4'b0000, 32'h0, 1);
    issue(1, 3'b001, 32'h11, 32'h1234, 32'h0, 1, 4'b0000, 32'h12341234, 1);
    issue(0, 3'b011, 32'h10, 32'h0, 32'h0, 1, 4'b0000, 32'h0, 1);
    repeat (2) @(posedge clk);
    #1;

    rsp_ready = 1'b0;
    issue(0, 3'b010, 32'h10, 32'h0, 32'hDEAD7AEF, 0, 4'b0000, 32'h0, 1);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("bp_rsp_valid", {31'h0, rsp_valid}, 32'h1);
      chk("bp_rsp_rdata", rsp_rdata, 32'hDEAD7AEF);
      chk("bp_req_ready", {31'h0, req_ready}, 32'h0);
      @(posedge clk);
      #1;
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    #2;
    chk("bp_done_req_ready", {31'h0, req_ready}, 32'h1);
    chk("bp_done_rsp_valid", {31'h0, rsp_valid}, 32'h0);
    @(posedge clk);
    #1;

    rsp_ready = 1'b0;
    issue(0, 3'b010, 32'h10, 32'h0, 32'h0, 0, 4'b0000, 32'h0, 0);
    @(posedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    chk("mid_rst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
    chk("mid_rst_rsp_rdata", rsp_rdata, 32'h0);
    chk("mid_rst_rsp_err", {31'h0, rsp_err}, 32'h0);
    req_valid  = 1'b1;
    req_we     = 1'b1;
    req_funct3 = 3'b010;
    req_addr   = 32'h10;
    req_wdata  = 32'h55555555;
    #1;
    chk("mid_rst_wr_en", {28'h0, mem_byte_wr_en}, 32'h0);
    req_valid = 1'b0;
    req_we    = 1'b0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    #1;
    chk("post_rst_req_ready", {31'h0, req_ready}, 32'h1);
    chk("post_rst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;

    issue(1, 3'b001, 32'h12, 32'hCAFE, 32'h0, 0, 4'b1100, 32'hCAFECAFE, 1);
    issue(0, 3'b010, 32'h410, 32'h0, 32'hCAFE7AEF, 0, 4'b0000, 32'h0, 1);
    issue(1, 3'b100, 32'h10, 32'h11, 32'h0, 1, 4'b0000, 32'h11111111, 1);
    issue(0, 3'b001, 32'h13, 32'h0, 32'h0, 1, 4'b0000, 32'h0, 1);
    issue(0, 3'b010, 32'h10, 32'h0, 32'hCAFE7AEF, 0, 4'b0000, 32'h0, 1);

    n = 0;
    while (q.size() != 0 && n < 20) begin
      @(posedge clk);
      n++;
    end
    #2;
    chk("drain", q.size(), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
